seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational integer ALU in the bytecode execution datapath.
- Adds a start/done handshake and operand capture.
- Completes IMUL/IDIV/IREM with iterative multi-cycle units; all other ops complete in one cycle.
- Adds variable shift amounts and an unsigned right shift.
- The stack/execute controller issues one op, waits for done, then pushes result_lo (and result_hi for IMUL when required).

Parameters:
- WIDTH, 32: operand and result width, in bits; must be at least 4.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from operand_b.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op_select  in  4  opcode, captured with start.
- operand_a  in  WIDTH  first operand, captured with start.
- operand_b  in  WIDTH  second operand, captured with start.
- busy  out  1  multi-cycle op in progress; start is ignored while high.
- done  out  1  one-cycle pulse; result_lo/result_hi are valid in this cycle.
- result_lo  out  WIDTH  primary result.
- result_hi  out  WIDTH  upper product word (IMUL); 0 for all other ops.
- div_by_zero  out  1  valid with done; set for IDIV/IREM when operand_b=0.
- illegal_op  out  1  valid with done; set for an unassigned opcode.

Behaviour:
- Reset: state IDLE. busy, done, div_by_zero and illegal_op are 0. result_lo and result_hi are 0. The iteration counter is 0. Reset during ITER or FIXUP aborts the op with no done pulse.
- Opcodes (all arithmetic is two's complement, wrapping modulo 2^WIDTH):
  - 0 IINC: a+1.
  - 1 IADD: a+b.
  - 2 ISUB: a-b.
  - 3 IMUL: signed 2W-bit product; {hi,lo} = a*b.
  - 4 IDIV: signed quotient, truncated toward zero.
  - 5 IREM: signed remainder; its sign follows the dividend.
  - 6 IAND, 7 IOR, 8 IXOR: bitwise.
  - 9 INEG: arithmetic negate, 0-a.
  - 10 ISHL: a << b[SHW-1:0].
  - 11 ISHR: arithmetic a >>> b[SHW-1:0].
  - 12 IUSHR: logical a >> b[SHW-1:0].
  - 13-15: illegal.
- Capture: on the edge where start=1 and busy=0, the opcode and operands are registered. Input changes after that edge have no effect on the op.
- Single-cycle ops (including illegal opcodes): the result is registered on the capture edge; done=1 in the next cycle and the FSM stays in IDLE. start may be asserted every cycle, giving one done per cycle.
- Multi-cycle ops (IMUL/IDIV/IREM) use FSM IDLE -> ITER -> FIXUP -> IDLE:
  - ITER runs exactly WIDTH cycles, with the counter counting WIDTH-1 down to 0.
  - Multiply is shift-add on the operand magnitudes.
  - Divide is restoring, one quotient bit per cycle, on the operand magnitudes.
  - FIXUP applies signs: the product is negated if sign(a)≠sign(b); the quotient likewise; the remainder takes the sign of a.
  - Results are registered at the end of FIXUP.
- Latency: if start is sampled in cycle t, done=1 in cycle t+1 for single-cycle ops and in cycle t+WIDTH+2 for multi-cycle ops.
- busy: high in cycles t+1 .. t+WIDTH+1, and low in the done cycle. A new start in the done cycle is therefore accepted.
- Divide by zero: the ITER/FIXUP timing is unchanged. result_lo=0, result_hi=0, div_by_zero=1 with done.
- Overflow: IDIV with MIN/-1 gives MIN; IREM with MIN/-1 gives 0; no flag is raised. IMUL with MIN*MIN gives hi=2^(W-2), lo=0.
- Shift amount: only b[SHW-1:0] is used; upper bits of b are ignored.
- Illegal opcode: result_lo=result_hi=0, illegal_op=1, done pulses with single-cycle latency.
- Output hold: result_lo, result_hi and both flags hold their values until the next done. done is never high for two consecutive cycles from the same op.
- Start while busy: ignored entirely; it is not queued.

Test Plan:
- Reset, then single-cycle ops issued back-to-back on consecutive cycles (WIDTH=32): IADD 0xFFFFFFFF+1 -> 0x00000000; ISUB 5-7 -> 0xFFFFFFFE; INEG 1 -> 0xFFFFFFFF; IUSHR 0x80000000 by 31 -> 1; ISHR 0x80000000 by 4 -> 0xF8000000; ISHL 1 by b=0x21 -> 2. Expect one done per cycle and busy never high.
- IMUL -3*7 -> lo=0xFFFFFFEB, hi=0xFFFFFFFF. IMUL 0x80000000*0x80000000 -> lo=0, hi=0x40000000. Expect done exactly 34 cycles after start and busy high for 33 cycles.
- IDIV -7/2 -> -3 (0xFFFFFFFD); IREM -7/2 -> -1; IREM 7/-2 -> 1; IDIV 0x80000000/-1 -> 0x80000000, with div_by_zero=0 in every case.
- IDIV 5/0 -> result_lo=0 and div_by_zero=1 at cycle t+34. A following IADD clears the flag on its done.
- Error and handshake corner cases:
  - Opcode 14 -> illegal_op=1 and result 0 at t+1.
  - start pulsed with changing operands during an IMUL busy window -> ignored; the original product is returned.
  - A new IADD started in the IMUL done cycle -> accepted, done at the next cycle.
- rst asserted at ITER cycle 10 of an IDIV -> next cycle busy=0, done=0, results 0. No done appears afterward, and a fresh IADD works normally.

Source files
------------

// File: rtl/seq_alu.sv
// Registered integer ALU with a start/done handshake. Most ops finish in one
// cycle; IMUL/IDIV/IREM run iterative shift-add / restoring-divide units.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op_select,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [3:0] OP_IINC  = 4'd0;
    localparam logic [3:0] OP_IADD  = 4'd1;
    localparam logic [3:0] OP_ISUB  = 4'd2;
    localparam logic [3:0] OP_IMUL  = 4'd3;
    localparam logic [3:0] OP_IDIV  = 4'd4;
    localparam logic [3:0] OP_IREM  = 4'd5;
    localparam logic [3:0] OP_IAND  = 4'd6;
    localparam logic [3:0] OP_IOR   = 4'd7;
    localparam logic [3:0] OP_IXOR  = 4'd8;
    localparam logic [3:0] OP_INEG  = 4'd9;
    localparam logic [3:0] OP_ISHL  = 4'd10;
    localparam logic [3:0] OP_ISHR  = 4'd11;
    localparam logic [3:0] OP_IUSHR = 4'd12;
    localparam int         CW       = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic               dbz_q, dbz_d, ill_q, ill_d, done_q, done_d;

    logic [SHW-1:0]     sh_amt;
    logic [WIDTH-1:0]   mag_a, mag_b, single_res, mul_addend, quo_neg, rem_neg;
    logic               is_multi, is_illegal;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign sh_amt   = operand_b[SHW-1:0];
    assign mag_a    = operand_a[WIDTH-1] ? ('0 - operand_a) : operand_a;
    assign mag_b    = operand_b[WIDTH-1] ? ('0 - operand_b) : operand_b;
    assign is_multi = (op_select == OP_IMUL) || (op_select == OP_IDIV) || (op_select == OP_IREM);

    always_comb begin
        single_res = '0;
        is_illegal = 1'b0;
        case (op_select)
            OP_IINC:  single_res = operand_a + WIDTH'(1);
            OP_IADD:  single_res = operand_a + operand_b;
            OP_ISUB:  single_res = operand_a - operand_b;
            OP_IAND:  single_res = operand_a & operand_b;
            OP_IOR:   single_res = operand_a | operand_b;
            OP_IXOR:  single_res = operand_a ^ operand_b;
            OP_INEG:  single_res = '0 - operand_a;
            OP_ISHL:  single_res = operand_a << sh_amt;
            OP_ISHR:  single_res = $signed(operand_a) >>> sh_amt;
            OP_IUSHR: single_res = operand_a >> sh_amt;
            OP_IMUL, OP_IDIV, OP_IREM: single_res = '0;
            default:  is_illegal = 1'b1;
        endcase
    end

    // One iteration step: opnd_q holds |a| for multiply and |b| for divide.
    assign mul_addend = lo_q[0] ? opnd_q : '0;
    assign mul_sum    = acc_q + {1'b0, mul_addend};
    assign div_shift  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, opnd_q};
    assign prod       = {acc_q[WIDTH-1:0], lo_q};
    assign prod_neg   = '0 - prod;
    assign quo_neg    = '0 - lo_q;
    assign rem_neg    = '0 - acc_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        count_d  = count_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_multi) begin
                    state_d  = ITER;
                    op_d     = op_select;
                    sign_a_d = operand_a[WIDTH-1];
                    sign_b_d = operand_b[WIDTH-1];
                    b_zero_d = (operand_b == '0);
                    opnd_d   = (op_select == OP_IMUL) ? mag_a : mag_b;
                    lo_d     = (op_select == OP_IMUL) ? mag_b : mag_a;
                    acc_d    = '0;
                    count_d  = CW'(WIDTH - 1);
                end else if (start) begin
                    res_lo_d = single_res;
                    res_hi_d = '0;
                    dbz_d    = 1'b0;
                    ill_d    = is_illegal;
                    done_d   = 1'b1;
                end
            end
            ITER: begin
                if (op_q == OP_IMUL) begin
                    acc_d = mul_sum >> 1;
                    lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    acc_d = div_diff;
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift;
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            FIXUP: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                ill_d    = 1'b0;
                res_hi_d = '0;
                dbz_d    = b_zero_q && (op_q != OP_IMUL);
                if (op_q == OP_IMUL) begin
                    {res_hi_d, res_lo_d} = (sign_a_q ^ sign_b_q) ? prod_neg : prod;
                end else if (b_zero_q) begin
                    res_lo_d = '0;
                end else if (op_q == OP_IDIV) begin
                    res_lo_d = (sign_a_q ^ sign_b_q) ? quo_neg : lo_q;
                end else begin
                    res_lo_d = sign_a_q ? rem_neg : acc_q[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations from a behavioural model are
// queued when an op is accepted and compared when done pulses.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op_select;
    logic [31:0] operand_a, operand_b;
    logic        busy, done, div_by_zero, illegal_op;
    logic [31:0] result_lo, result_hi;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        logic        ill;
        int          lat;
        int          busy_cycles;
        int          issue_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic        in_reset;
    logic [31:0] last_lo, last_hi;
    logic        last_dbz, last_ill;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_select(op_select),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] w;
        e.lo = '0; e.hi = '0; e.dbz = 1'b0; e.ill = 1'b0;
        e.lat = 1; e.busy_cycles = 0; e.issue_cyc = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  e.lo = a + 32'd1;
            4'd1:  e.lo = a + b;
            4'd2:  e.lo = a - b;
            4'd3:  begin w = sa * sb; e.lo = w[31:0]; e.hi = w[63:32]; end
            4'd4:  if (b == 0) e.dbz = 1'b1; else begin w = sa / sb; e.lo = w[31:0]; end
            4'd5:  if (b == 0) e.dbz = 1'b1; else begin w = sa % sb; e.lo = w[31:0]; end
            4'd6:  e.lo = a & b;
            4'd7:  e.lo = a | b;
            4'd8:  e.lo = a ^ b;
            4'd9:  e.lo = 32'd0 - a;
            4'd10: e.lo = a << b[4:0];
            4'd11: e.lo = $signed(a) >>> b[4:0];
            4'd12: e.lo = a >> b[4:0];
            default: e.ill = 1'b1;
        endcase
        if (op == 4'd3 || op == 4'd4 || op == 4'd5) begin
            e.lat = 34;
            e.busy_cycles = 33;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (in_reset) begin
            last_lo = '0; last_hi = '0; last_dbz = 1'b0; last_ill = 1'b0;
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                $display("done cyc=%0d lo=%h hi=%h dbz=%0b ill=%0b", cyc, result_lo, result_hi, div_by_zero, illegal_op);
                if (sb_q.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result_lo", {32'd0, result_lo}, {32'd0, mon_e.lo});
                    check("result_hi", {32'd0, result_hi}, {32'd0, mon_e.hi});
                    check("flags", {62'd0, div_by_zero, illegal_op}, {62'd0, mon_e.dbz, mon_e.ill});
                    check("latency", 64'(cyc - mon_e.issue_cyc), 64'(mon_e.lat));
                    check("busy_cycles", 64'(busy_cnt), 64'(mon_e.busy_cycles));
                end
                busy_cnt = 0;
                last_lo = result_lo; last_hi = result_hi;
                last_dbz = div_by_zero; last_ill = illegal_op;
            end else begin
                check("hold", {result_hi, result_lo}, {last_hi, last_lo});
                check("hold_flags", {62'd0, div_by_zero, illegal_op}, {62'd0, last_dbz, last_ill});
            end
        end
    end

    task automatic issue_now(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start = 1'b1; op_select = op; operand_a = a; operand_b = b;
        if (!busy) begin
            e = model(op, a, b);
            e.issue_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue_now(op, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; op_select = '0; operand_a = '0; operand_b = '0;
        in_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", {result_hi, result_lo}, 64'd0);
        check("rst_flags", {62'd0, div_by_zero, illegal_op}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        in_reset = 1'b0;

        // Back-to-back single-cycle ops
        issue(4'd1, 32'hFFFFFFFF, 32'd1);
        issue(4'd2, 32'd5, 32'd7);
        issue(4'd9, 32'd1, 32'd0);
        issue(4'd12, 32'h80000000, 32'd31);
        issue(4'd11, 32'h80000000, 32'd4);
        issue(4'd10, 32'd1, 32'h21);
        issue(4'd0, 32'h7FFFFFFF, 32'd0);
        issue(4'd6, 32'hF0F0F0F0, 32'h0FF00FF0);
        issue(4'd7, 32'hF0F0F0F0, 32'h0FF00FF0);
        issue(4'd8, 32'hF0F0F0F0, 32'h0FF00FF0);
        idle(2);
        drain();

        // Multi-cycle ops
        issue(4'd3, 32'hFFFFFFFD, 32'd7);        idle(1); drain();
        issue(4'd3, 32'h80000000, 32'h80000000); idle(1); drain();
        issue(4'd4, 32'hFFFFFFF9, 32'd2);        idle(1); drain();
        issue(4'd5, 32'hFFFFFFF9, 32'd2);        idle(1); drain();
        issue(4'd5, 32'd7, 32'hFFFFFFFE);        idle(1); drain();
        issue(4'd4, 32'h80000000, 32'hFFFFFFFF); idle(1); drain();
        issue(4'd5, 32'h80000000, 32'hFFFFFFFF); idle(1); drain();
        issue(4'd4, 32'd5, 32'd0);               idle(1); drain();
        issue(4'd1, 32'd3, 32'd4);               idle(1); drain();

        // Illegal opcodes
        issue(4'd14, 32'h1234, 32'h5678);
        issue(4'd13, 32'h1, 32'h2);
        issue(4'd15, 32'h3, 32'h4);
        idle(2);
        drain();

        // Starts during a busy window must be ignored
        issue(4'd3, 32'h00012345, 32'hFFFF0001);
        for (int i = 0; i < 8; i++)
            issue(4'($urandom_range(0, 15)), $urandom, $urandom);
        idle(1);
        drain();

        // New op accepted in the done cycle of a multi-cycle op
        issue(4'd3, 32'd1000, 32'hFFFFFFFB);
        idle(1);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_wait", {63'd0, seen}, 64'd1);
        if (seen) issue_now(4'd1, 32'd10, 32'd20);
        idle(2);
        drain();

        // Reset in the middle of an IDIV aborts it with no done
        issue(4'd4, 32'd1000, 32'd7);
        idle(10);
        in_reset = 1'b1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_result", {result_hi, result_lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        in_reset = 1'b0;
        idle(45);
        issue(4'd1, 32'd100, 32'd23);
        idle(1);
        drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
